// File: rtl/riscv_ctrl_pkg.sv
// Shared types and default sizing for the RISC-V run controller.
package riscv_ctrl_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int IMEM_AW_DEF = 8;
  localparam int NREGS_DEF   = 32;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DUMP,
    ST_DONE
  } run_state_e;

endpackage

// File: rtl/riscv_run_ctrl.sv
// Session controller: streams a program into instruction memory, releases the
// core for a fixed number of cycles, then streams the register file back out.
module riscv_run_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int IMEM_AW = IMEM_AW_DEF,
  parameter int NREGS   = NREGS_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CNT_W-1:0]         run_len,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [XLEN-1:0]          ld_data,
  input  logic                     ld_last,
  output logic                     imem_we,
  output logic [IMEM_AW-1:0]       imem_waddr,
  output logic [XLEN-1:0]          imem_wdata,
  output logic                     core_rst_n,
  output logic [$clog2(NREGS)-1:0] rf_raddr,
  input  logic [XLEN-1:0]          rf_rdata,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [$clog2(NREGS)-1:0] dump_idx,
  output logic [XLEN-1:0]          dump_data,
  output logic                     dump_last,
  output logic                     busy,
  output logic                     done,
  output logic                     ovf
);

  localparam int RF_AW = $clog2(NREGS);
  localparam logic [IMEM_AW-1:0] WADDR_MAX = '1;
  localparam logic [RF_AW-1:0]   IDX_LAST  = RF_AW'(NREGS - 1);

  run_state_e         r_state;
  logic [IMEM_AW-1:0] r_waddr;
  logic [CNT_W-1:0]   r_cnt;
  logic [RF_AW-1:0]   r_idx;
  logic               r_ovf;

  logic w_ld_hs;
  logic w_at_max;
  logic w_ld_end;

  assign w_ld_hs  = (r_state == ST_LOAD) && ld_valid;
  assign w_at_max = (r_waddr == WADDR_MAX);
  // The last memory slot closes the load even without ld_last; the pointer never wraps.
  assign w_ld_end = w_ld_hs && (ld_last || w_at_max);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_waddr <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cnt   <= run_len;
            r_waddr <= '0;
            r_idx   <= '0;
            r_ovf   <= 1'b0;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_ld_hs) begin
            if (!w_at_max) r_waddr <= r_waddr + 1'b1;
            if (w_at_max && !ld_last) r_ovf <= 1'b1;
          end
          if (w_ld_end) r_state <= (r_cnt == '0) ? ST_DUMP : ST_RUN;
        end
        ST_RUN: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) r_state <= ST_DUMP;
        end
        ST_DUMP: begin
          if (dump_ready) begin
            if (r_idx == IDX_LAST) r_state <= ST_DONE;
            else r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ld_ready   = (r_state == ST_LOAD);
  assign imem_we    = w_ld_hs;
  assign imem_waddr = r_waddr;
  assign imem_wdata = ld_data;
  assign core_rst_n = (r_state == ST_RUN);
  assign rf_raddr   = r_idx;
  assign dump_valid = (r_state == ST_DUMP);
  assign dump_idx   = r_idx;
  assign dump_data  = rf_rdata;
  assign dump_last  = (r_state == ST_DUMP) && (r_idx == IDX_LAST);
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Scoreboard bench for riscv_run_ctrl: default-size instance plus a 4-word IMEM instance.
module tb_riscv_run_ctrl;

  localparam int XLEN = 32;
  localparam int AW   = 8;
  localparam int AW2  = 2;
  localparam int NR   = 32;
  localparam int CW   = 16;
  localparam int RAW  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            start;
  logic [CW-1:0]   run_len;
  logic            ld_valid, ld_ready, ld_last;
  logic [XLEN-1:0] ld_data;
  logic            imem_we;
  logic [AW-1:0]   imem_waddr;
  logic [XLEN-1:0] imem_wdata;
  logic            core_rst_n;
  logic [RAW-1:0]  rf_raddr, dump_idx;
  logic [XLEN-1:0] rf_rdata, dump_data;
  logic            dump_valid, dump_ready, dump_last;
  logic            busy, done, ovf;

  logic            start2;
  logic [CW-1:0]   run_len2;
  logic            ld_valid2, ld_ready2, ld_last2;
  logic [XLEN-1:0] ld_data2;
  logic            imem_we2;
  logic [AW2-1:0]  imem_waddr2;
  logic [XLEN-1:0] imem_wdata2;
  logic            core_rst_n2;
  logic [RAW-1:0]  rf_raddr2, dump_idx2;
  logic [XLEN-1:0] rf_rdata2, dump_data2;
  logic            dump_valid2, dump_ready2, dump_last2;
  logic            busy2, done2, ovf2;

  int n_checks = 0;
  int n_fail   = 0;
  int n_core_hi, n_done, n_dump;

  logic [AW+XLEN-1:0] wr_q[$];
  logic [RAW-1:0]     dump_q[$];
  logic [AW+XLEN-1:0] m_wr;
  logic [RAW-1:0]     m_dx;

  function automatic logic [XLEN-1:0] rf_model(input logic [RAW-1:0] idx);
    return 32'hC0DE_0000 + 32'(idx) * 32'h0001_0203;
  endfunction

  assign rf_rdata  = rf_model(rf_raddr);
  assign rf_rdata2 = rf_model(rf_raddr2);

  riscv_run_ctrl #(.XLEN(XLEN), .IMEM_AW(AW), .NREGS(NR), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .run_len(run_len),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
    .dump_data(dump_data), .dump_last(dump_last),
    .busy(busy), .done(done), .ovf(ovf)
  );

  riscv_run_ctrl #(.XLEN(XLEN), .IMEM_AW(AW2), .NREGS(NR), .CNT_W(CW)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .run_len(run_len2),
    .ld_valid(ld_valid2), .ld_ready(ld_ready2), .ld_data(ld_data2), .ld_last(ld_last2),
    .imem_we(imem_we2), .imem_waddr(imem_waddr2), .imem_wdata(imem_wdata2),
    .core_rst_n(core_rst_n2), .rf_raddr(rf_raddr2), .rf_rdata(rf_rdata2),
    .dump_valid(dump_valid2), .dump_ready(dump_ready2), .dump_idx(dump_idx2),
    .dump_data(dump_data2), .dump_last(dump_last2),
    .busy(busy2), .done(done2), .ovf(ovf2)
  );

  // Monitor for the default instance: pops the write and dump scoreboards.
  always @(negedge clk) begin
    if (rst_n) begin
      if (core_rst_n) n_core_hi++;
      if (done) n_done++;
      if (imem_we) begin
        n_checks++;
        if (wr_q.size() == 0) begin
          n_fail++;
          $display("FAIL imem_write unexpected: addr=%0d data=%h, none expected", imem_waddr, imem_wdata);
        end else begin
          m_wr = wr_q.pop_front();
          if ({imem_waddr, imem_wdata} !== m_wr) begin
            n_fail++;
            $display("FAIL imem_write: addr=%0d data=%h, expected addr=%0d data=%h",
                     imem_waddr, imem_wdata, m_wr[AW+XLEN-1:XLEN], m_wr[XLEN-1:0]);
          end
        end
      end
      if (dump_valid && dump_ready) begin
        n_dump++;
        n_checks++;
        if (dump_q.size() == 0) begin
          n_fail++;
          $display("FAIL dump_beat unexpected: idx=%0d", dump_idx);
        end else begin
          m_dx = dump_q.pop_front();
          if (dump_idx !== m_dx || dump_data !== rf_model(m_dx) || dump_last !== (m_dx == 5'd31)) begin
            n_fail++;
            $display("FAIL dump_beat: idx=%0d data=%h last=%b, expected idx=%0d data=%h last=%b",
                     dump_idx, dump_data, dump_last, m_dx, rf_model(m_dx), (m_dx == 5'd31));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session(input logic [CW-1:0] len);
    step();
    start   = 1'b1;
    run_len = len;
    for (int i = 0; i < NR; i++) dump_q.push_back(RAW'(i));
    step();
    start     = 1'b0;
    run_len   = 16'hFFFF;
    n_core_hi = 0;
    n_done    = 0;
    n_dump    = 0;
  endtask

  task automatic load_words(input int n, input bit toggle, input int base);
    logic [XLEN-1:0] d;
    for (int i = 0; i < n; i++) begin
      d        = 32'h1000_0000 + 32'(base) + 32'(i);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = (i == n - 1);
      wr_q.push_back({AW'(i), d});
      step();
      if (toggle && i < n - 1) begin
        ld_valid = 1'b0;
        ld_last  = 1'b1;
        ld_data  = 32'hDEAD_BEEF;
        step();
      end
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic wait_dump(input int budget);
    int k = 0;
    @(negedge clk);
    while (!dump_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (!dump_valid) begin
      n_fail++;
      $display("FAIL wait_dump: dump_valid=%b after %0d cycles, expected 1", dump_valid, k);
    end
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    @(negedge clk);
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL wait_done: done=%b after %0d cycles, expected 1", done, k);
    end
  endtask

  task automatic end_checks(input int exp_core);
    step();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL end_busy: got %b expected 0", busy);
    end
    n_checks++;
    if (n_core_hi != exp_core) begin
      n_fail++; $display("FAIL core_release_cycles: got %0d expected %0d", n_core_hi, exp_core);
    end
    n_checks++;
    if (n_done != 1) begin
      n_fail++; $display("FAIL done_pulses: got %0d expected 1", n_done);
    end
    n_checks++;
    if (n_dump != NR || dump_q.size() != 0 || wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: dumps=%0d pend_dump=%0d pend_wr=%0d, expected %0d/0/0",
               n_dump, dump_q.size(), wr_q.size(), NR);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    ld_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({core_rst_n, ld_ready, imem_we, dump_valid, done, busy, ovf} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: core=%b rdy=%b we=%b dv=%b done=%b busy=%b ovf=%b, expected all 0",
               core_rst_n, ld_ready, imem_we, dump_valid, done, busy, ovf);
    end
    n_checks++;
    if ({busy2, core_rst_n2, ld_ready2, ovf2} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_outputs2: busy=%b core=%b rdy=%b ovf=%b, expected 0", busy2, core_rst_n2, ld_ready2, ovf2);
    end
    step();
    rst_n    = 1'b1;
    ld_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || ld_ready !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: busy=%b rdy=%b expected 0/0", busy, ld_ready);
    end
  endtask

  task automatic test_basic();
    start_session(16'd20);
    @(negedge clk);
    n_checks++;
    if (ld_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL load_entry: rdy=%b busy=%b expected 1/1", ld_ready, busy);
    end
    step();
    load_words(5, 1'b0, 0);
    wait_done(200);
    end_checks(20);
  endtask

  task automatic test_toggle();
    start_session(16'd2);
    load_words(6, 1'b1, 100);
    wait_done(200);
    end_checks(2);
  endtask

  task automatic test_runlen0();
    start_session(16'd0);
    load_words(3, 1'b0, 200);
    @(negedge clk);
    n_checks++;
    if (dump_valid !== 1'b1 || dump_idx !== 5'd0 || core_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL runlen0_dump_entry: dv=%b idx=%0d core=%b expected 1/0/0", dump_valid, dump_idx, core_rst_n);
    end
    wait_done(200);
    end_checks(0);
  endtask

  task automatic test_dump_stall();
    dump_ready = 1'b0;
    start_session(16'd1);
    load_words(1, 1'b0, 300);
    wait_dump(20);
    step();
    dump_ready = 1'b1;
    repeat (7) step();
    dump_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (dump_idx !== 5'd7 || dump_data !== rf_model(5'd7) || dump_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold: idx=%0d data=%h dv=%b expected 7/%h/1", dump_idx, dump_data, dump_valid, rf_model(5'd7));
      end
      step();
    end
    dump_ready = 1'b1;
    step();
    @(negedge clk);
    n_checks++;
    if (dump_idx !== 5'd8) begin
      n_fail++; $display("FAIL stall_advance: idx=%0d expected 8", dump_idx);
    end
    wait_done(200);
    end_checks(1);
  endtask

  task automatic test_overflow();
    logic [AW2+XLEN-1:0] q2[$];
    logic [AW2+XLEN-1:0] e;
    logic [XLEN-1:0]     d;
    int n_wr2 = 0;
    int k = 0;
    step();
    start2   = 1'b1;
    run_len2 = 16'd3;
    step();
    start2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d         = 32'h0000_AB00 + 32'(i);
      ld_valid2 = 1'b1;
      ld_data2  = d;
      if (i < 4) q2.push_back({AW2'(i), d});
      @(negedge clk);
      if (imem_we2) begin
        n_wr2++;
        n_checks++;
        if (q2.size() == 0) begin
          n_fail++; $display("FAIL ovf_write unexpected: addr=%0d data=%h", imem_waddr2, imem_wdata2);
        end else begin
          e = q2.pop_front();
          if ({imem_waddr2, imem_wdata2} !== e) begin
            n_fail++;
            $display("FAIL ovf_write: addr=%0d data=%h expected addr=%0d data=%h",
                     imem_waddr2, imem_wdata2, e[AW2+XLEN-1:XLEN], e[XLEN-1:0]);
          end
        end
      end
      if (i == 4) begin
        n_checks++;
        if (ld_ready2 !== 1'b0 || ovf2 !== 1'b1 || core_rst_n2 !== 1'b1) begin
          n_fail++;
          $display("FAIL ovf_state: rdy=%b ovf=%b core=%b expected 0/1/1", ld_ready2, ovf2, core_rst_n2);
        end
      end
      step();
    end
    ld_valid2 = 1'b0;
    n_checks++;
    if (n_wr2 != 4 || q2.size() != 0) begin
      n_fail++; $display("FAIL ovf_write_count: got %0d pending %0d expected 4/0", n_wr2, q2.size());
    end
    while (busy2 && k < 100) begin
      step();
      k++;
    end
    @(negedge clk);
    n_checks++;
    if (busy2 !== 1'b0 || ovf2 !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: busy=%b ovf=%b expected 0/1", busy2, ovf2);
    end
  endtask

  task automatic test_reset_mid_run();
    start_session(16'd20);
    load_words(2, 1'b0, 400);
    repeat (5) step();
    @(negedge clk);
    n_checks++;
    if (core_rst_n !== 1'b1) begin
      n_fail++; $display("FAIL mid_run_core: got %b expected 1", core_rst_n);
    end
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || core_rst_n !== 1'b0 || dump_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_run_reset: busy=%b core=%b dv=%b expected 0/0/0", busy, core_rst_n, dump_valid);
    end
    dump_q.delete();
    start_session(16'd3);
    load_words(4, 1'b0, 500);
    wait_done(200);
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++; $display("FAIL fresh_ovf: got %b expected 0", ovf);
    end
    end_checks(3);
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    run_len     = '0;
    ld_valid    = 1'b0;
    ld_data     = '0;
    ld_last     = 1'b0;
    dump_ready  = 1'b1;
    start2      = 1'b0;
    run_len2    = '0;
    ld_valid2   = 1'b0;
    ld_data2    = '0;
    ld_last2    = 1'b0;
    dump_ready2 = 1'b1;
    n_core_hi   = 0;
    n_done      = 0;
    n_dump      = 0;
    test_reset();
    test_basic();
    test_toggle();
    test_runlen0();
    test_dump_stall();
    test_overflow();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/riscv_run_ctrl.md
RISCV_RUN_CTRL -- requirements
Module: riscv_run_ctrl

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, data width; IMEM_AW, default 8, instruction-memory address width (depth 2**IMEM_AW); NREGS, default 32, register-file entries; CNT_W, default 16, run-length counter width.
REQ-002 The clock port SHALL be: clk  in  1  sole clock, rising edge.
REQ-003 The reset port SHALL be: rst_n  in  1  reset, synchronous, active-low.
REQ-004 The control ports SHALL be: start  in  1  begin session; run_len  in  CNT_W  cycles to release core, sampled with start.
REQ-005 The load-stream ports SHALL be: ld_valid  in  1; ld_ready  out  1; ld_data  in  XLEN; ld_last  in  1  final instruction word.
REQ-006 The instruction-memory ports SHALL be: imem_we  out  1; imem_waddr  out  IMEM_AW; imem_wdata  out  XLEN.
REQ-007 The core port SHALL be: core_rst_n  out  1  active-low reset to core.
REQ-008 The register-file ports SHALL be: rf_raddr  out  $clog2(NREGS); rf_rdata  in  XLEN, combinational read.
REQ-009 The dump-stream ports SHALL be: dump_valid  out  1; dump_ready  in  1; dump_idx  out  $clog2(NREGS); dump_data  out  XLEN; dump_last  out  1.
REQ-010 The status ports SHALL be: busy  out  1; done  out  1  one-cycle pulse; ovf  out  1  sticky load overflow.

Function
REQ-011 The FSM SHALL have the states IDLE, LOAD, RUN, DUMP and DONE.
REQ-012 IDLE: start=1 SHALL latch run_len, clear waddr, ovf and the dump index, and move to LOAD next cycle; start SHALL be ignored in all other states.
REQ-013 LOAD: ld_ready SHALL be 1; imem_we SHALL equal ld_valid&ld_ready in the same cycle, with imem_waddr=waddr and imem_wdata=ld_data.
REQ-014 Each LOAD handshake SHALL increment waddr by 1.
REQ-015 A handshake with ld_last=1 SHALL end LOAD; the next state SHALL be RUN, or DUMP when the latched run_len=0.
REQ-016 A handshake at waddr=2**IMEM_AW-1 without ld_last SHALL set ovf, end LOAD as in REQ-015, and SHALL NOT wrap waddr.
REQ-017 RUN: core_rst_n SHALL be 1 for exactly run_len cycles and 0 in every other state; the state SHALL then move to DUMP.
REQ-018 DUMP: dump_valid SHALL be 1; rf_raddr and dump_idx SHALL equal the dump index; dump_data SHALL equal rf_rdata combinationally.
REQ-019 In DUMP, dump_valid&dump_ready SHALL advance the index by 1; while dump_ready=0, all dump outputs SHALL hold.
REQ-020 dump_last SHALL be 1 when the index is NREGS-1; a handshake at that index SHALL move the FSM to DONE.
REQ-021 DONE SHALL last one cycle, assert done=1, and then return to IDLE.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 ovf SHALL hold its value until the next accepted start or reset.
REQ-024 ld_ready, imem_we and dump_valid SHALL be 0 outside LOAD and DUMP respectively.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force IDLE from any state, including mid-LOAD, mid-RUN and mid-DUMP.
REQ-026 The same reset SHALL clear waddr, the run counter, the dump index and ovf.
REQ-027 While in reset and IDLE, the outputs SHALL be: core_rst_n=0, ld_ready=0, imem_we=0, dump_valid=0, done=0, busy=0.

Structure
REQ-028 The state enum and the default parameter constants SHALL reside in shared package riscv_ctrl_pkg.
REQ-029 The block SHALL be a single module with no sub-modules; counters and the FSM are inline.

Verification
REQ-030 Start with run_len=20, then load 5 words with ld_last on the 5th -> imem writes at addresses 0..4, core_rst_n=1 for exactly 20 cycles, then 32 dump beats and one done pulse.
REQ-031 Toggle ld_valid every other cycle during LOAD -> writes occur only on handshake cycles and the addresses stay contiguous.
REQ-032 Use IMEM_AW=2 and stream 6 words without ld_last -> 4 writes, ovf=1, FSM enters RUN, ld_ready=0 after the 4th word.
REQ-033 Use run_len=0 -> core_rst_n never goes to 1, and DUMP begins the cycle after the last load word.
REQ-034 Hold dump_ready=0 for 3 cycles at index 7 -> dump_idx and dump_data stay stable, and index 8 follows the next handshake.
REQ-035 Assert rst_n=0 for 1 cycle mid-RUN -> IDLE, core_rst_n=0 and busy=0 next cycle; a fresh start then completes normally with ovf=0.
